// File: rtl/mem_arbiter_pkg.sv
// mypack: shared types and constants for the unified memory port arbiter.
package mypack;
  localparam int ARB_CNT_W = 4;
  typedef enum logic [1:0] {ARB_IDLE, ARB_IF, ARB_LS, ARB_DONE} arb_state_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant selector, one-hot {ls,if}; MEM_ARB_RR_EN alternates winners on ties.
module mem_arb_pick (
  input  logic       if_req,
  input  logic       ls_req,
`ifdef MEM_ARB_RR_EN
  input  logic       last_gnt,
`endif
  output logic [1:0] gnt
);
  logic ls_pref;
`ifdef MEM_ARB_RR_EN
  assign ls_pref = ~last_gnt;
`else
  assign ls_pref = 1'b1;
`endif
  assign gnt[1] = ls_req & (~if_req | ls_pref);
  assign gnt[0] = if_req & ~gnt[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between fetch and load/store; MEM_ARB_RR_EN enables round-robin ties.
module mem_arbiter
  import mypack::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  arb_state_e           state_q, state_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 src_q, src_d, we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic [1:0]           gnt;
`ifdef MEM_ARB_RR_EN
  logic                 last_gnt_q, last_gnt_d;
  mem_arb_pick u_pick (.if_req(if_req), .ls_req(ls_req), .last_gnt(last_gnt_q), .gnt(gnt));
  assign last_gnt_d = (state_q == ARB_IDLE && |gnt) ? gnt[1] : last_gnt_q;
  always_ff @(posedge clk) last_gnt_q <= rst ? 1'b0 : last_gnt_d;
`else
  mem_arb_pick u_pick (.if_req(if_req), .ls_req(ls_req), .gnt(gnt));
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      ARB_IDLE: if (|gnt) begin
        state_d = gnt[1] ? ARB_LS : ARB_IF;
        cnt_d   = ARB_CNT_W'(WAIT_CYC - 1);
        src_d   = gnt[1];
        we_d    = gnt[1] & ls_we;
        addr_d  = gnt[1] ? ls_addr : if_addr;
        wdata_d = gnt[1] ? ls_wdata : wdata_q;
      end
      ARB_IF, ARB_LS: if (cnt_q == '0) begin
        state_d    = ARB_DONE;
        if_rdata_d = (state_q == ARB_IF) ? mem_rdata : if_rdata_q;
        ls_rdata_d = (state_q == ARB_LS && !we_q) ? mem_rdata : ls_rdata_q;
      end else begin
        cnt_d = cnt_q - ARB_CNT_W'(1);
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      src_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end
  assign mem_en    = (state_q == ARB_IF) || (state_q == ARB_LS);
  assign mem_we    = (state_q == ARB_LS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign if_ack    = (state_q == ARB_DONE) && !src_q;
  assign ls_ack    = (state_q == ARB_DONE) && src_q;
  assign busy      = state_q != ARB_IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter (WAIT_CYC=2 and WAIT_CYC=1); tie order follows MEM_ARB_RR_EN.
module tb_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 0, ls_req = 0, ls_we = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, ls_ack, mem_en, mem_we, busy;
  logic        if_req1 = 0;
  logic [31:0] if_addr1 = 0;
  logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ack1, ls_ack1, mem_en1, mem_we1, busy1;
  int          errors = 0, checks = 0;
  logic [2:0]  tie_exp;
  logic        seen, was_ls;
  always #5 clk = ~clk;
  assign mem_rdata  = (mem_addr == 32'h100) ? 32'hDEADBEEF : mem_addr + 32'hCAFE0000;
  assign mem_rdata1 = mem_addr1 + 32'hCAFE0000;
  mem_arbiter #(.AW(32), .DW(32), .WAIT_CYC(2)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
    .ls_ack(ls_ack), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));
  mem_arbiter #(.AW(32), .DW(32), .WAIT_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'h0), .ls_wdata(32'h0), .ls_rdata(ls_rdata1),
    .ls_ack(ls_ack1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_en", {31'b0, mem_en}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_ack", {30'b0, if_ack, ls_ack}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ifrd", if_rdata, 0);
    chk("rst_lsrd", ls_rdata, 0);
    // IF read of 0x100; address change mid-access must be ignored
    if_req = 1; if_addr = 32'h100;
    tick();
    chk("if_c1_en", {31'b0, mem_en}, 1);
    chk("if_c1_addr", mem_addr, 32'h100);
    chk("if_c1_busy", {31'b0, busy}, 1);
    chk("if_c1_we", {31'b0, mem_we}, 0);
    if_addr = 32'h999;
    tick();
    chk("if_c2_en", {31'b0, mem_en}, 1);
    chk("if_c2_addr", mem_addr, 32'h100);
    chk("if_c2_ack", {31'b0, if_ack}, 0);
    tick();
    chk("if_c3_ack", {30'b0, if_ack, ls_ack}, 2'b10);
    chk("if_c3_en", {31'b0, mem_en}, 0);
    chk("if_c3_rd", if_rdata, 32'hDEADBEEF);
    if_req = 0;
    tick();
    chk("if_c4_ack", {31'b0, if_ack}, 0);
    chk("if_c4_busy", {31'b0, busy}, 0);
    // request dropped after cycle 1 still completes
    if_req = 1; if_addr = 32'h300;
    tick();
    if_req = 0;
    tick();
    tick();
    chk("drop_ack", {31'b0, if_ack}, 1);
    chk("drop_rd", if_rdata, 32'hCAFE0300);
    tick();
    // load then store: store must not touch ls_rdata
    ls_req = 1; ls_we = 0; ls_addr = 32'h40;
    tick(); tick(); tick();
    chk("ld_ack", {30'b0, if_ack, ls_ack}, 2'b01);
    chk("ld_rd", ls_rdata, 32'hCAFE0040);
    chk("ld_ifrd", if_rdata, 32'hCAFE0300);
    ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'h12345678;
    tick();
    chk("st_c1_busy", {31'b0, busy}, 0);
    tick();
    chk("st_c1_we", {31'b0, mem_we}, 1);
    chk("st_c1_addr", mem_addr, 32'h200);
    chk("st_c1_wd", mem_wdata, 32'h12345678);
    tick();
    chk("st_c2_we", {31'b0, mem_we}, 1);
    tick();
    chk("st_ack", {30'b0, if_ack, ls_ack}, 2'b01);
    chk("st_we_off", {31'b0, mem_we}, 0);
    chk("st_lsrd", ls_rdata, 32'hCAFE0040);
    ls_req = 0; ls_we = 0;
    tick();
    // tie, both held: winners in order of acks
`ifdef MEM_ARB_RR_EN
    tie_exp = 3'b101;
`else
    tie_exp = 3'b111;
`endif
    if_req = 1; ls_req = 1; if_addr = 32'h500; ls_addr = 32'h600;
    for (int k = 0; k < 3; k++) begin
      seen = 0; was_ls = 0;
      for (int t = 0; t < 8 && !seen; t++) begin
        tick();
        if (if_ack || ls_ack) begin
          seen = 1;
          was_ls = ls_ack;
          chk($sformatf("tie%0d_lat", k), t, k == 0 ? 2 : 3);
        end
      end
      chk($sformatf("tie%0d_seen", k), {31'b0, seen}, 1);
      chk($sformatf("tie%0d_ls", k), {31'b0, was_ls}, {31'b0, tie_exp[2-k]});
    end
    if_req = 0; ls_req = 0;
    tick(); tick(); tick(); tick(); tick();
    chk("tie_idle", {31'b0, busy}, 0);
    // reset in cycle 2 of an IF access
    if_req = 1; if_addr = 32'h100;
    tick();
    tick();
    rst = 1;
    tick();
    chk("mrst_busy", {31'b0, busy}, 0);
    chk("mrst_ack", {30'b0, if_ack, ls_ack}, 0);
    chk("mrst_en", {31'b0, mem_en}, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_ifrd", if_rdata, 0);
    chk("mrst_lsrd", ls_rdata, 0);
    rst = 0; if_req = 0;
    tick();
    chk("mrst_noack", {31'b0, if_ack}, 0);
    // WAIT_CYC=1 instance: ack in cycle 2
    if_req1 = 1; if_addr1 = 32'h10;
    tick();
    chk("w1_c1_en", {31'b0, mem_en1}, 1);
    chk("w1_c1_ack", {31'b0, if_ack1}, 0);
    if_req1 = 0;
    tick();
    chk("w1_c2_ack", {31'b0, if_ack1}, 1);
    chk("w1_c2_en", {31'b0, mem_en1}, 0);
    chk("w1_rd", if_rdata1, 32'hCAFE0010);
    tick();
    chk("w1_c3_busy", {31'b0, busy1}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory port of the multicycle RV core between two requesters: instruction fetch (IF) and load/store (LS). The block sits between the microcoded control unit's fetch/memory states and the memory macro. It arbitrates requests, latches the winning request, and sequences a fixed-latency access with a wait-state counter. It returns read data with a one-cycle acknowledge pulse.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `WAIT_CYC`, 2, memory access latency in cycles (legal 1..15)

- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `if_req` in 1: fetch request, held until `if_ack`
- `if_addr` in AW: fetch address
- `if_rdata` out DW: fetched word, valid when `if_ack`=1, held until next IF read
- `if_ack` out 1: one-cycle completion pulse for IF
- `ls_req` in 1: load/store request, held until `ls_ack`
- `ls_we` in 1: 1 = store, 0 = load
- `ls_addr` in AW: load/store address
- `ls_wdata` in DW: store data
- `ls_rdata` out DW: load data, valid when `ls_ack`=1, held until next LS load
- `ls_ack` out 1: one-cycle completion pulse for LS
- `mem_en` out 1: memory access active
- `mem_we` out 1: memory write strobe
- `mem_addr` out AW: memory address (registered)
- `mem_wdata` out DW: memory write data (registered)
- `mem_rdata` in DW: memory read data, valid on last wait cycle
- `busy` out 1: FSM not in IDLE

## Operation
- FSM states: IDLE, ACC_IF, ACC_LS, DONE.
- IDLE: no request → stay. Request(s) present → pick winner, latch addr/wdata/we into regs, load `cnt`=WAIT_CYC-1, go ACC_IF/ACC_LS.
- Tie (both requesting, base build): LS wins.
- ACC_x: `mem_en`=1; `mem_we`=1 only in ACC_LS with latched we=1. `cnt` decrements each cycle. At `cnt`==0 → DONE; on that edge capture `mem_rdata` into `if_rdata`/`ls_rdata` (loads/fetches only).
- DONE: `if_ack` or `ls_ack` =1 for exactly this cycle; `mem_en`=0; next edge → IDLE unconditionally.
- Stores leave `ls_rdata` unchanged.
- Requests are sampled only in IDLE. Address/data changes during ACC_x are ignored.
- A requester dropping `req` mid-access does not abort it; the access completes and ack still pulses.
- `cnt` is 4 bits and never wraps: it is loaded only in IDLE.

## Timing
- Reset values: `if_ack`=`ls_ack`=`mem_en`=`mem_we`=`busy`=0; `mem_addr`, `mem_wdata`, `if_rdata`, `ls_rdata`=0; state IDLE; `cnt`=0.
- Cycle 0: req high in IDLE. Cycles 1..WAIT_CYC: ACC, `mem_en`=1. Cycle WAIT_CYC+1: DONE, ack=1. Cycle WAIT_CYC+2: IDLE, arbitration again.
- Throughput: one access per WAIT_CYC+2 cycles. Requester must deassert or change req the cycle after ack; req still high in the IDLE cycle after ack starts a new access.
- Reset mid-access: immediate return to IDLE next edge. No ack for the aborted access; `mem_en` low the cycle after `rst`.
- `rst` has priority over all transitions.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on ties. A 1-bit `last_gnt` register (reset = IF) records the last winner; on a tie the other port wins. Single requests are granted regardless of `last_gnt`. `last_gnt` updates on every grant.
- Undefined: fixed LS-over-IF priority; no `last_gnt` register.

## Structure
- `mypack` gains `arb_state_e` {ARB_IDLE, ARB_IF, ARB_LS, ARB_DONE} and `ARB_CNT_W`=4.
- One sub-module: `mem_arb_pick`. It is the grant selector (inputs `if_req`, `ls_req`, `last_gnt`; outputs grant one-hot) and contains the `MEM_ARB_RR_EN` logic.
- FSM, counter and data registers live in `mem_arbiter`.

## Test plan
- IF read, WAIT_CYC=2: `if_req`=1, `if_addr`=0x100, memory returns 0xDEADBEEF → `mem_en` high cycles 1–2, `if_ack` pulse cycle 3, `if_rdata`=0xDEADBEEF.
- LS store: `ls_we`=1, addr 0x200, wdata 0x12345678 → `mem_we`=1 two cycles, `mem_addr`=0x200, `ls_ack` cycle 3, `ls_rdata` unchanged.
- Tie, both req held continuously, base build → grant order LS, LS, LS. With `MEM_ARB_RR_EN` → order LS, IF, LS.
- `rst` asserted in cycle 2 of an IF access → no `if_ack`, `busy`=0 next cycle, all outputs at reset values.
- `if_req` dropped after cycle 1 → access completes, `if_ack` still pulses in cycle 3. WAIT_CYC=1 sweep → ack in cycle 2.
